mem_stream_reader: RTL and testbench

Bus initiator for the data memory port. On a start command it walks a word-strided region of data memory, one byte-per-word entry at a time, and streams each byte out over a valid/ready handshake. It sits beside the memory stage and drives the same address / write_enable / write_data / read_data port the processor uses, for example to export decrypted plaintext to an output peripheral. An optional build feature zeroes each entry after it is consumed, so key material or plaintext does not persist.

---
 rtl/mem_stream_reader.sv | 108 ++++++++++
 tb/tb_mem_stream_reader.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mem_stream_reader.sv
// mem_stream_reader: walks a word-strided region of data memory and streams the low byte of each entry over valid/ready.
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   start, base_addr, length     command; sampled only in IDLE
//   busy, done                   status; done is a one-cycle completion pulse
//   mem_address, mem_write_enable, mem_write_data, mem_read_data
//                                data memory port; read data is combinational
//   out_data, out_valid, out_ready
//                                byte stream handshake; out_data is registered
// Build option: MEM_STREAM_CLEAR_EN adds a CLEAR state that writes zero over
// each entry in the cycle after it is consumed.
module mem_stream_reader #(
    parameter int N     = 16,
    parameter int BITS  = 32,
    parameter int LEN_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     base_addr,
    input  logic [LEN_W-1:0] length,
    output logic             busy,
    output logic             done,
    output logic [N-1:0]     mem_address,
    output logic             mem_write_enable,
    output logic [BITS-1:0]  mem_write_data,
    input  logic [BITS-1:0]  mem_read_data,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready
);
`ifdef MEM_STREAM_CLEAR_EN
    typedef enum logic [2:0] {IDLE, FETCH, SEND, CLEAR, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, FETCH, SEND, DONE} state_t;
`endif
    state_t state_q, state_d;
    logic [N-1:0] addr_q, addr_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [7:0] data_q, data_d;
    logic adv;
    logic unused_rd;
    assign unused_rd = ^mem_read_data[BITS-1:8];
    always_comb begin
        state_d = state_q;
        addr_d = addr_q;
        cnt_d = cnt_q;
        data_d = data_q;
        adv = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                if (length != '0) begin
                    addr_d = base_addr;
                    cnt_d = length;
                    state_d = FETCH;
                end else begin
                    state_d = DONE;
                end
            end
            FETCH: begin
                data_d = mem_read_data[7:0];
                state_d = SEND;
            end
            SEND: if (out_ready) begin
`ifdef MEM_STREAM_CLEAR_EN
                state_d = CLEAR;
`else
                adv = 1'b1;
`endif
            end
`ifdef MEM_STREAM_CLEAR_EN
            CLEAR: adv = 1'b1;
`endif
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Advance to the next word; the low address bits ride along untouched.
        if (adv) begin
            addr_d = addr_q + N'(4);
            cnt_d = cnt_q - LEN_W'(1);
            state_d = (cnt_q == LEN_W'(1)) ? DONE : FETCH;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q <= '0;
            cnt_q <= '0;
            data_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            cnt_q <= cnt_d;
            data_q <= data_d;
        end
    end
    assign busy = (state_q != IDLE) && (state_q != DONE);
    assign done = (state_q == DONE);
    assign out_valid = (state_q == SEND);
    assign out_data = data_q;
    assign mem_address = addr_q;
    assign mem_write_data = '0;
`ifdef MEM_STREAM_CLEAR_EN
    assign mem_write_enable = (state_q == CLEAR);
`else
    assign mem_write_enable = 1'b0;
`endif
endmodule

// File: tb/tb_mem_stream_reader.sv
// tb_mem_stream_reader: table-driven cycle checks of mem_stream_reader against a simple memory model.
module tb_mem_stream_reader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [15:0] base_addr = '0;
    logic [11:0] length = '0;
    logic busy, done, mem_write_enable, out_valid;
    logic [15:0] mem_address;
    logic [31:0] mem_write_data, mem_read_data;
    logic [7:0] out_data;
    logic out_ready = 1'b1;
    logic [31:0] mem [0:16383];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;
    assign mem_read_data = mem[mem_address[15:2]];

    mem_stream_reader dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .mem_address(mem_address),
        .mem_write_enable(mem_write_enable), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    typedef struct {
        string nm;
        logic st;
        logic [15:0] b;
        logic [11:0] l;
        logic r;
        logic eb, ed, ev, ew;
        logic [7:0] edat;
        logic [15:0] ea;
    } vec_t;
    vec_t q[$];

    task automatic add(input string nm, input logic st, input logic [15:0] b, input logic [11:0] l,
                       input logic r, input logic eb, input logic ed, input logic ev,
                       input logic [7:0] edat, input logic [15:0] ea, input logic ew);
        vec_t t;
        t.nm = nm; t.st = st; t.b = b; t.l = l; t.r = r;
        t.eb = eb; t.ed = ed; t.ev = ev; t.edat = edat; t.ea = ea; t.ew = ew;
        q.push_back(t);
    endtask

    // One clock; the memory model commits any write the DUT presented this cycle.
    task automatic step();
        logic w;
        logic [15:0] a;
        logic [31:0] d;
        w = mem_write_enable;
        a = mem_address;
        d = mem_write_data;
        @(posedge clk);
        if (w) mem[a[15:2]] = d;
        #1;
    endtask

    task automatic chk(input string nm, input logic eb, input logic ed, input logic ev,
                       input logic [7:0] edat, input logic [15:0] ea, input logic ew);
        logic [59:0] got, exp;
        got = {busy, done, out_valid, out_data, mem_address, mem_write_enable, mem_write_data};
        exp = {eb, ed, ev, edat, ea, ew, 32'h0};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got busy/done/valid/data/addr/we/wdata=%h required %h", nm, got, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
        mem[16'h0100 >> 2] = 32'hDEAD_BE41;
        mem[16'h0104 >> 2] = 32'h1234_5642;
        mem[16'h0108 >> 2] = 32'hFFFF_FF43;
        mem[16'hFFFC >> 2] = 32'hA5A5_A55A;
        mem[16'h0000 >> 2] = 32'h0000_0077;
`ifdef MEM_STREAM_CLEAR_EN
        add("clr_start", 1, 16'h0100, 2, 1, 1, 0, 0, 8'h00, 16'h0100, 0);
        add("clr_send0", 0, 16'h0, 0, 1, 1, 0, 1, 8'h41, 16'h0100, 0);
        add("clr_wr0",   0, 16'h0, 0, 1, 1, 0, 0, 8'h41, 16'h0100, 1);
        add("clr_fetch1",0, 16'h0, 0, 1, 1, 0, 0, 8'h41, 16'h0104, 0);
        add("clr_send1", 0, 16'h0, 0, 1, 1, 0, 1, 8'h42, 16'h0104, 0);
        add("clr_wr1",   0, 16'h0, 0, 1, 1, 0, 0, 8'h42, 16'h0104, 1);
        add("clr_done",  0, 16'h0, 0, 1, 0, 1, 0, 8'h42, 16'h0108, 0);
        add("clr_idle",  0, 16'h0, 0, 1, 0, 0, 0, 8'h42, 16'h0108, 0);
        add("re_start",  1, 16'h0100, 2, 1, 1, 0, 0, 8'h42, 16'h0100, 0);
        add("re_send0",  0, 16'h0, 0, 1, 1, 0, 1, 8'h00, 16'h0100, 0);
        add("re_wr0",    0, 16'h0, 0, 1, 1, 0, 0, 8'h00, 16'h0100, 1);
        add("re_fetch1", 0, 16'h0, 0, 1, 1, 0, 0, 8'h00, 16'h0104, 0);
        add("re_send1",  0, 16'h0, 0, 1, 1, 0, 1, 8'h00, 16'h0104, 0);
        add("re_wr1",    0, 16'h0, 0, 1, 1, 0, 0, 8'h00, 16'h0104, 1);
        add("re_done",   0, 16'h0, 0, 1, 0, 1, 0, 8'h00, 16'h0108, 0);
        add("re_idle",   0, 16'h0, 0, 1, 0, 0, 0, 8'h00, 16'h0108, 0);
`else
        add("bas_start", 1, 16'h0100, 3, 1, 1, 0, 0, 8'h00, 16'h0100, 0);
        add("bas_send0", 0, 16'h0, 0, 1, 1, 0, 1, 8'h41, 16'h0100, 0);
        add("bas_fetch1",0, 16'h0, 0, 1, 1, 0, 0, 8'h41, 16'h0104, 0);
        add("bas_send1", 0, 16'h0, 0, 1, 1, 0, 1, 8'h42, 16'h0104, 0);
        add("bas_fetch2",0, 16'h0, 0, 1, 1, 0, 0, 8'h42, 16'h0108, 0);
        add("bas_send2", 0, 16'h0, 0, 1, 1, 0, 1, 8'h43, 16'h0108, 0);
        add("bas_done",  0, 16'h0, 0, 1, 0, 1, 0, 8'h43, 16'h010C, 0);
        add("bas_idle",  0, 16'h0, 0, 1, 0, 0, 0, 8'h43, 16'h010C, 0);
        add("bp_start",  1, 16'h0100, 3, 1, 1, 0, 0, 8'h43, 16'h0100, 0);
        add("bp_send0",  0, 16'h0, 0, 1, 1, 0, 1, 8'h41, 16'h0100, 0);
        add("bp_fetch1", 0, 16'h0, 0, 1, 1, 0, 0, 8'h41, 16'h0104, 0);
        for (int i = 0; i < 6; i++)
            add($sformatf("bp_hold%0d", i), 0, 16'h0, 0, 0, 1, 0, 1, 8'h42, 16'h0104, 0);
        add("bp_fetch2", 0, 16'h0, 0, 1, 1, 0, 0, 8'h42, 16'h0108, 0);
        add("bp_send2",  0, 16'h0, 0, 1, 1, 0, 1, 8'h43, 16'h0108, 0);
        add("bp_done",   0, 16'h0, 0, 1, 0, 1, 0, 8'h43, 16'h010C, 0);
        add("bp_idle",   0, 16'h0, 0, 1, 0, 0, 0, 8'h43, 16'h010C, 0);
        add("len0_done", 1, 16'h0200, 0, 1, 0, 1, 0, 8'h43, 16'h010C, 0);
        add("len0_idle", 0, 16'h0, 0, 1, 0, 0, 0, 8'h43, 16'h010C, 0);
        add("ign_start", 1, 16'h0100, 2, 1, 1, 0, 0, 8'h43, 16'h0100, 0);
        add("ign_send0", 1, 16'h0200, 5, 1, 1, 0, 1, 8'h41, 16'h0100, 0);
        add("ign_fetch1",1, 16'h0200, 5, 1, 1, 0, 0, 8'h41, 16'h0104, 0);
        add("ign_send1", 0, 16'h0, 0, 1, 1, 0, 1, 8'h42, 16'h0104, 0);
        add("ign_done",  0, 16'h0, 0, 1, 0, 1, 0, 8'h42, 16'h0108, 0);
        add("ign_indone",1, 16'hFFFC, 2, 1, 0, 0, 0, 8'h42, 16'h0108, 0);
        add("wrap_start",1, 16'hFFFC, 2, 1, 1, 0, 0, 8'h42, 16'hFFFC, 0);
        add("wrap_send0",0, 16'h0, 0, 1, 1, 0, 1, 8'h5A, 16'hFFFC, 0);
        add("wrap_fetch",0, 16'h0, 0, 1, 1, 0, 0, 8'h5A, 16'h0000, 0);
        add("wrap_send1",0, 16'h0, 0, 1, 1, 0, 1, 8'h77, 16'h0000, 0);
        add("wrap_done", 0, 16'h0, 0, 1, 0, 1, 0, 8'h77, 16'h0004, 0);
        add("wrap_idle", 0, 16'h0, 0, 1, 0, 0, 0, 8'h77, 16'h0004, 0);
`endif
        rst = 1'b1;
        step();
        step();
        chk("rst_init", 0, 0, 0, 8'h00, 16'h0000, 0);
        rst = 1'b0;
        foreach (q[i]) begin
            start = q[i].st;
            base_addr = q[i].b;
            length = q[i].l;
            out_ready = q[i].r;
            step();
            chk(q[i].nm, q[i].eb, q[i].ed, q[i].ev, q[i].edat, q[i].ea, q[i].ew);
        end
        start = 1'b1; base_addr = 16'h0100; length = 12'd3; out_ready = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        chk("rst_mid0", 0, 0, 0, 8'h00, 16'h0000, 0);
        step();
        chk("rst_mid1", 0, 0, 0, 8'h00, 16'h0000, 0);
        rst = 1'b0;
        step();
        chk("rst_rel0", 0, 0, 0, 8'h00, 16'h0000, 0);
        step();
        chk("rst_rel1", 0, 0, 0, 8'h00, 16'h0000, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
